// File: rtl/uart_param_fifo_if.sv
// rtl/uart_param_fifo_if.sv - Handshake, data and status bundle for uart_param_fifo
interface uart_param_fifo_if #(
    parameter int DBITS = 8,
    parameter int ABITS = 4
);
    logic             CLR_I;
    logic             WE_I;
    logic [DBITS-1:0] W_DATA_I;
    logic             RE_I;
    logic [DBITS-1:0] R_DATA_O;
    logic             FULL_O;
    logic             EMPTY_O;
    logic             HALF_FULL_O;
    logic [ABITS:0]   AFULL_LVL_I;
    logic [ABITS:0]   AEMPTY_LVL_I;
    logic             AFULL_O;
    logic             AEMPTY_O;
    logic [ABITS:0]   LEVEL_O;
    logic             OVF_O;
    logic             UDF_O;

    // FIFO side: consumes requests and thresholds, produces data and status
    modport slave (
        input  CLR_I, WE_I, W_DATA_I, RE_I, AFULL_LVL_I, AEMPTY_LVL_I,
        output R_DATA_O, FULL_O, EMPTY_O, HALF_FULL_O, AFULL_O, AEMPTY_O,
               LEVEL_O, OVF_O, UDF_O
    );

    // Client side: drives requests and thresholds, observes data and status
    modport master (
        output CLR_I, WE_I, W_DATA_I, RE_I, AFULL_LVL_I, AEMPTY_LVL_I,
        input  R_DATA_O, FULL_O, EMPTY_O, HALF_FULL_O, AFULL_O, AEMPTY_O,
               LEVEL_O, OVF_O, UDF_O
    );
endinterface

// File: rtl/uart_param_fifo.sv
// rtl/uart_param_fifo.sv - Parametrised show-ahead FIFO with level/threshold status; UART_FIFO_ERR_FLAGS_EN enables sticky OVF/UDF
module uart_param_fifo #(
    parameter int DBITS = 8,
    parameter int ABITS = 4
) (
    input  logic                 CLK_I,
    input  logic                 RST_NI,
    uart_param_fifo_if.slave     bus
);
    localparam logic [ABITS:0] DEPTH = {1'b1, {ABITS{1'b0}}};
    localparam logic [ABITS:0] HALF  = DEPTH >> 1;

    logic [DBITS-1:0] mem [DEPTH];
    logic [ABITS:0]   w_ptr;
    logic [ABITS:0]   r_ptr;
    logic [ABITS:0]   level;
    logic             full;
    logic             empty;
    logic             rd_acc;
    logic             wr_acc;
    logic             wr_en;
    logic             rd_en;

    // Status is decoded from the registered pointers only
    assign level = w_ptr - r_ptr;
    assign full  = (level == DEPTH);
    assign empty = (level == '0);

    // A read frees a slot on the same edge, so a full FIFO can still take a write
    assign rd_acc = bus.RE_I & ~empty;
    assign wr_acc = bus.WE_I & (~full | rd_acc);
    assign wr_en  = wr_acc & ~bus.CLR_I;
    assign rd_en  = rd_acc & ~bus.CLR_I;

    assign bus.LEVEL_O     = level;
    assign bus.FULL_O      = full;
    assign bus.EMPTY_O     = empty;
    assign bus.HALF_FULL_O = (level >= HALF);
    assign bus.AFULL_O     = (level >= bus.AFULL_LVL_I);
    assign bus.AEMPTY_O    = (level <= bus.AEMPTY_LVL_I);
    assign bus.R_DATA_O    = mem[r_ptr[ABITS-1:0]];

    // Pointer update; flush wins over any access in the same cycle
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            w_ptr <= '0;
            r_ptr <= '0;
        end else if (bus.CLR_I) begin
            w_ptr <= '0;
            r_ptr <= '0;
        end else begin
            if (wr_acc) w_ptr <= w_ptr + 1'b1;
            if (rd_acc) r_ptr <= r_ptr + 1'b1;
        end
    end

    // Storage array, intentionally not reset
    always_ff @(posedge CLK_I) begin
        if (wr_en) mem[w_ptr[ABITS-1:0]] <= bus.W_DATA_I;
    end

`ifdef UART_FIFO_ERR_FLAGS_EN
    logic ovf;
    logic udf;

    // Sticky rejected-access flags, cleared by flush or reset
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else if (bus.CLR_I) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (bus.WE_I & ~wr_acc) ovf <= 1'b1;
            if (bus.RE_I & ~rd_acc) udf <= 1'b1;
        end
    end

    assign bus.OVF_O = ovf;
    assign bus.UDF_O = udf;
`else
    logic unused_rd_en;
    assign unused_rd_en = rd_en;
    assign bus.OVF_O    = 1'b0;
    assign bus.UDF_O    = 1'b0;
`endif

`ifdef UART_FIFO_ERR_FLAGS_EN
    logic unused_rd_en;
    assign unused_rd_en = rd_en;
`endif
endmodule
